// File: rtl/cpld_io_cmd_bank_pkg.sv
// Shared IO CPLD address definitions: command opcodes and the command bank base.
// No logic; constants only.
// No flow control.
package cpld_io_cmd_bank_pkg;

    typedef enum logic [1:0] {
        OP_SR  = 2'b00,
        OP_TGL = 2'b01,
        OP_PLS = 2'b10,
        OP_CTL = 2'b11
    } op_e;

    localparam logic [10:0] BANK_BASE_ADDR = 11'h100;
    localparam int          CH_IDX_W       = 5;
    localparam int          TIMER_W        = 8;

endpackage

// File: rtl/cpld_io_cmd_bank_if.sv
// Buffered DSP external-bus strobes and address lines seen by the IO CPLD.
// Combinational wires, no latency.
// No backpressure; the DSP owns the bus timing.
interface cpld_io_cmd_bank_if #(
    parameter int AB_W = 11
);
    logic            re;
    logic            we;
    logic [AB_W-1:0] ab;

    modport master (output re, output we, output ab);
    modport slave  (input  re, input  we, input  ab);
endinterface

// File: rtl/strobe_debounce_edge.sv
// Debounces an active-low strobe over DEB_DEPTH samples and emits a one-cycle fire.
// fire is combinational from the sample register: DEB_DEPTH-1 cycles after the first low sample.
// No backpressure; the strobe must be seen high again before it can re-fire.
module strobe_debounce_edge #(
    parameter int DEB_DEPTH = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic strobe_n,
    output logic fire
);

    logic [DEB_DEPTH-1:0] sh_q, sh_d;
    logic                 deb;
    logic                 deb_prev_q, deb_prev_d;

    always_comb begin
        sh_d       = (sh_q << 1) | DEB_DEPTH'(strobe_n);
        deb        = ~|sh_q;
        deb_prev_d = deb;
        fire       = deb & ~deb_prev_q;
    end

    // Samples reset to "high" so a strobe held low across reset still needs the full debounce.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_q       <= '1;
            deb_prev_q <= 1'b0;
        end else begin
            sh_q       <= sh_d;
            deb_prev_q <= deb_prev_d;
        end
    end

endmodule

// File: rtl/cpld_io_cmd_bank.sv
// DSP-bus command register bank: set/clear, toggle, timed pulse and error clear per channel.
// Output changes DEB_DEPTH cycles after the strobe is first sampled low.
// No backpressure; rejected commands only raise the sticky err flag.
module cpld_io_cmd_bank
    import cpld_io_cmd_bank_pkg::*;
#(
    parameter int                NUM_CH    = 16,
    parameter int                AB_W      = 11,
    parameter logic [AB_W-1:0]   BASE_ADDR = AB_W'(BANK_BASE_ADDR),
    parameter int                DEB_DEPTH = 2,
    parameter int                PULSE_LEN = 8,
    parameter logic [NUM_CH-1:0] RESET_VAL = '0
) (
    input  logic                clkDspIn,
    input  logic                dsp_reset,
    cpld_io_cmd_bank_if.slave   bus,
    output logic [NUM_CH-1:0]   ch_out,
    output logic                pulse_busy,
    output logic                err
);

    logic [AB_W-1:0]     ab_buf_q, ab_buf_d;
    logic [NUM_CH-1:0]   ch_out_q, ch_out_d;
    logic                busy_q, busy_d;
    logic                err_q, err_d;
    logic [TIMER_W-1:0]  timer_q, timer_d;
    logic [CH_IDX_W-1:0] owner_q, owner_d;

    logic                wr_fire, rd_fire;
    logic                hit, ch_ok, own_hit, err_set, err_clr;
    logic [CH_IDX_W-1:0] ch;
    op_e                 op;
    logic [NUM_CH-1:0]   sel_mask, own_mask;

    strobe_debounce_edge #(.DEB_DEPTH(DEB_DEPTH)) u_deb_we (
        .clk      (clkDspIn),
        .rst_n    (dsp_reset),
        .strobe_n (bus.we),
        .fire     (wr_fire)
    );

    strobe_debounce_edge #(.DEB_DEPTH(DEB_DEPTH)) u_deb_re (
        .clk      (clkDspIn),
        .rst_n    (dsp_reset),
        .strobe_n (bus.re),
        .fire     (rd_fire)
    );

    always_comb begin
        ab_buf_d = bus.ab;
        hit      = ab_buf_q[AB_W-1:7] == BASE_ADDR[AB_W-1:7];
        ch       = ab_buf_q[6:2];
        op       = op_e'(ab_buf_q[1:0]);
        ch_ok    = {1'b0, ch} < 6'(NUM_CH);
        own_hit  = busy_q && (owner_q == ch);
        for (int i = 0; i < NUM_CH; i++) begin
            sel_mask[i] = (ch == CH_IDX_W'(i));
            own_mask[i] = (owner_q == CH_IDX_W'(i));
        end
    end

    always_comb begin
        ch_out_d = ch_out_q;
        busy_d   = busy_q;
        timer_d  = timer_q;
        owner_d  = owner_q;
        err_set  = 1'b0;
        err_clr  = 1'b0;

        if (busy_q) begin
            if (timer_q == '0) begin
                ch_out_d = ch_out_d & ~own_mask;
                busy_d   = 1'b0;
            end else begin
                timer_d = timer_q - 1'b1;
            end
        end

        // Commands are evaluated after the timer so they win in the expiry cycle.
        if (hit && (wr_fire || rd_fire)) begin
            if ((wr_fire && rd_fire) || !ch_ok) begin
                err_set = 1'b1;
            end else if (wr_fire) begin
                case (op)
                    OP_SR: begin
                        if (own_hit) busy_d = 1'b0;
                        ch_out_d = ch_out_d | sel_mask;
                    end
                    OP_TGL: begin
                        if (own_hit) busy_d = 1'b0;
                        ch_out_d = (ch_out_d & ~sel_mask) | (~ch_out_q & sel_mask);
                    end
                    OP_PLS: begin
                        if (busy_q && !own_hit) begin
                            err_set = 1'b1;
                        end else begin
                            ch_out_d = ch_out_d | sel_mask;
                            timer_d  = TIMER_W'(PULSE_LEN - 1);
                            busy_d   = 1'b1;
                            owner_d  = ch;
                        end
                    end
                    default: ;
                endcase
            end else begin
                case (op)
                    OP_SR, OP_PLS: begin
                        if (own_hit) busy_d = 1'b0;
                        ch_out_d = ch_out_d & ~sel_mask;
                    end
                    OP_CTL:  err_clr = 1'b1;
                    default: ;
                endcase
            end
        end

        err_d = err_set ? 1'b1 : (err_clr ? 1'b0 : err_q);
    end

    always_ff @(posedge clkDspIn or negedge dsp_reset) begin
        if (!dsp_reset) begin
            ab_buf_q <= '0;
            ch_out_q <= RESET_VAL;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
            timer_q  <= '0;
            owner_q  <= '0;
        end else begin
            ab_buf_q <= ab_buf_d;
            ch_out_q <= ch_out_d;
            busy_q   <= busy_d;
            err_q    <= err_d;
            timer_q  <= timer_d;
            owner_q  <= owner_d;
        end
    end

    assign ch_out     = ch_out_q;
    assign pulse_busy = busy_q;
    assign err        = err_q;

endmodule

// File: tb/tb_cpld_io_cmd_bank.sv
// Self-checking bench for cpld_io_cmd_bank: command vector table plus pulse, glitch and reset sequences.
module tb_cpld_io_cmd_bank;
    import cpld_io_cmd_bank_pkg::*;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] ch_out;
    logic        pulse_busy;
    logic        err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cpld_io_cmd_bank_if #(.AB_W(11)) bus ();

    cpld_io_cmd_bank #(
        .NUM_CH    (16),
        .AB_W      (11),
        .BASE_ADDR (11'h100),
        .DEB_DEPTH (2),
        .PULSE_LEN (8),
        .RESET_VAL (16'h0081)
    ) u_dut (
        .clkDspIn   (clk),
        .dsp_reset  (rst_n),
        .bus        (bus),
        .ch_out     (ch_out),
        .pulse_busy (pulse_busy),
        .err        (err)
    );

    typedef struct {
        logic        wr;
        logic        rd;
        logic        hit;
        logic [4:0]  ch;
        logic [1:0]  op;
        int          hold;
        logic [15:0] exp_out;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [15:0] out;
        logic        err;
    } exp_t;

    vec_t vecs[13];
    exp_t sb[$];

    function automatic logic [10:0] mk_addr(input logic hit, input logic [4:0] ch, input logic [1:0] op);
        mk_addr = {(hit ? 4'b0010 : 4'b0011), ch, op};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic bus_cycle(input logic wr, input logic rd, input logic hit,
                             input logic [4:0] ch, input logic [1:0] op, input int hold);
        bus.ab = mk_addr(hit, ch, op);
        tick(1);
        bus.we = ~wr;
        bus.re = ~rd;
        tick(hold);
        bus.we = 1'b1;
        bus.re = 1'b1;
        tick(2);
    endtask

    // Leaves the bench just past the edge where the pulse output rises.
    task automatic start_pulse(input logic [4:0] ch);
        bus.ab = mk_addr(1'b1, ch, OP_PLS);
        tick(1);
        bus.we = 1'b0;
        tick(2);
        bus.we = 1'b1;
        tick(1);
    endtask

    task automatic pulse_run(input logic [4:0] ch, input int retrig_i, output int hi, output int bz);
        bus.ab = mk_addr(1'b1, ch, OP_PLS);
        tick(1);
        bus.we = 1'b0;
        tick(2);
        bus.we = 1'b1;
        hi = 0;
        bz = 0;
        for (int i = 0; i < 30; i++) begin
            tick(1);
            if (ch_out[ch[3:0]]) hi++;
            if (pulse_busy) bz++;
            if (i == retrig_i - 3) bus.we = 1'b0;
            if (i == retrig_i - 1) bus.we = 1'b1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int   hi, bz;
        exp_t e;

        vecs[0]  = '{1'b0, 1'b1, 1'b1, 5'd0,  OP_SR,  3,  16'h0080, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 1'b1, 5'd7,  OP_SR,  3,  16'h0000, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 1'b1, 5'd3,  OP_SR,  3,  16'h0008, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 1'b1, 5'd3,  OP_SR,  3,  16'h0000, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 1'b1, 5'd5,  OP_TGL, 10, 16'h0020, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 1'b1, 5'd5,  OP_TGL, 3,  16'h0020, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 1'b1, 5'd5,  OP_TGL, 3,  16'h0000, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 1'b1, 5'd0,  OP_CTL, 3,  16'h0000, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 1'b1, 5'd16, OP_SR,  3,  16'h0000, 1'b1};
        vecs[9]  = '{1'b0, 1'b1, 1'b1, 5'd0,  OP_CTL, 3,  16'h0000, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 1'b1, 5'd15, OP_SR,  3,  16'h8000, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 1'b0, 5'd1,  OP_SR,  3,  16'h8000, 1'b0};
        vecs[12] = '{1'b0, 1'b1, 1'b1, 5'd15, OP_SR,  3,  16'h0000, 1'b0};

        bus.re = 1'b1;
        bus.we = 1'b1;
        bus.ab = '0;
        #1 rst_n = 1'b0;
        #11;
        chk("rst_out", ch_out, 16'h0081);
        chk("rst_busy", pulse_busy, 1'b0);
        chk("rst_err", err, 1'b0);
        tick(1);
        #2 rst_n = 1'b1;
        tick(2);

        foreach (vecs[i]) begin
            sb.push_back('{vecs[i].exp_out, vecs[i].exp_err});
            bus_cycle(vecs[i].wr, vecs[i].rd, vecs[i].hit, vecs[i].ch, vecs[i].op, vecs[i].hold);
            e = sb.pop_front();
            chk($sformatf("vec%0d_out", i), ch_out, e.out);
            chk($sformatf("vec%0d_err", i), err, e.err);
        end

        // Write latency: first low sample at edge k, output moves at edge k+2.
        bus.ab = mk_addr(1'b1, 5'd3, OP_SR);
        tick(1);
        bus.we = 1'b0;
        tick(1);
        chk("lat_k", ch_out[3], 1'b0);
        tick(1);
        chk("lat_k1", ch_out[3], 1'b0);
        tick(1);
        chk("lat_k2", ch_out[3], 1'b1);
        bus.we = 1'b1;
        tick(2);
        bus_cycle(1'b0, 1'b1, 1'b1, 5'd3, OP_SR, 2);
        chk("lat_clr", ch_out, 16'h0000);

        pulse_run(5'd0, -1, hi, bz);
        chk("pls_high", hi, 8);
        chk("pls_busy", bz, 8);
        pulse_run(5'd0, 4, hi, bz);
        chk("retrig_high", hi, 12);
        chk("retrig_busy", bz, 12);
        chk("retrig_end", ch_out, 16'h0000);

        start_pulse(5'd0);
        bus_cycle(1'b1, 1'b0, 1'b1, 5'd1, OP_PLS, 2);
        chk("coll_out", ch_out, 16'h0001);
        chk("coll_err", err, 1'b1);
        chk("coll_busy", pulse_busy, 1'b1);
        bus_cycle(1'b0, 1'b1, 1'b1, 5'd0, OP_CTL, 2);
        chk("ctl_err", err, 1'b0);
        chk("coll_end", ch_out, 16'h0000);

        start_pulse(5'd2);
        bus_cycle(1'b1, 1'b0, 1'b1, 5'd2, OP_TGL, 2);
        chk("tgl_cancel_out", ch_out, 16'h0000);
        chk("tgl_cancel_busy", pulse_busy, 1'b0);
        start_pulse(5'd6);
        bus_cycle(1'b1, 1'b0, 1'b1, 5'd6, OP_SR, 2);
        chk("sr_cancel_busy", pulse_busy, 1'b0);
        tick(10);
        chk("sr_cancel_out", ch_out, 16'h0040);
        bus_cycle(1'b0, 1'b1, 1'b1, 5'd6, OP_SR, 2);
        chk("sr_cancel_clr", ch_out, 16'h0000);

        bus.ab = mk_addr(1'b1, 5'd4, OP_SR);
        tick(1);
        bus.we = 1'b0;
        tick(1);
        bus.we = 1'b1;
        tick(4);
        chk("glitch_out", ch_out, 16'h0000);

        bus.ab = mk_addr(1'b1, 5'd2, OP_SR);
        tick(1);
        bus.we = 1'b0;
        bus.re = 1'b0;
        tick(3);
        bus.we = 1'b1;
        bus.re = 1'b1;
        tick(2);
        chk("both_out", ch_out, 16'h0000);
        chk("both_err", err, 1'b1);
        bus_cycle(1'b0, 1'b1, 1'b1, 5'd0, OP_CTL, 2);
        chk("both_ctl", err, 1'b0);

        // Reset between edges mid-pulse, with a write strobe held low across release.
        start_pulse(5'd4);
        tick(2);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out", ch_out, 16'h0081);
        chk("arst_busy", pulse_busy, 1'b0);
        bus.ab = mk_addr(1'b1, 5'd3, OP_SR);
        bus.we = 1'b0;
        tick(1);
        #2 rst_n = 1'b1;
        tick(1);
        chk("rel_e1", ch_out, 16'h0081);
        tick(1);
        chk("rel_e2", ch_out, 16'h0081);
        tick(1);
        chk("rel_e3", ch_out, 16'h0089);
        bus.we = 1'b1;
        tick(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
